fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for the kanade32 core. Generates word-aligned fetch addresses, runs a single-outstanding request/acknowledge transaction against instruction memory, buffers returned words, and presents them with `ins_op`/`func_code` fields split out to the control decoder over a valid/ready handshake. A redirect input from branch/jump resolution flushes buffered and in-flight instructions and restarts fetch at a new PC.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  core clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address, word-aligned.
- `imem_ack`  in  1  memory accepted request and `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word, sampled only when `imem_req && imem_ack`.
- `redirect`  in  1  one-cycle pulse: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored, forced to 0.
- `ins_valid`  out  1  head buffer entry valid.
- `ins_ready`  in  1  downstream accepts head entry.
- `ins_word`  out  32  head instruction word.
- `ins_pc`  out  32  address of head instruction.
- `ins_op`  out  6  `ins_word[31:26]`.
- `func_code`  out  6  `ins_word[5:0]`.

## Operation
- Registers: `fetch_pc` (reset `RESET_PC`), buffer of DEPTH entries {word, pc}, `count`, FSM state.
- FSM states: FETCH, DISCARD. Reset state FETCH.
- FETCH: `imem_req = (count < DEPTH)`, `imem_addr = fetch_pc`. On `imem_req && imem_ack`: push {imem_rdata, fetch_pc}, `fetch_pc += 4`.
- Request stability: once `imem_req` is high, it and `imem_addr` stay constant until the ack cycle, regardless of downstream pops.
- Pop: `ins_valid && ins_ready` removes head. Push and pop in the same cycle leave `count` unchanged.
- Redirect (highest priority over push/pop):
  - No request pending, or ack in same cycle: buffer cleared, ack data dropped, `fetch_pc = redirect_pc & ~3`, stay FETCH.
  - Request pending without ack: buffer cleared, `redirect_pc` latched into `fetch_pc`, go DISCARD.
- DISCARD: `imem_req` held high with the old address; on ack, data dropped, go FETCH. A further redirect in DISCARD overwrites the latched target.
- `fetch_pc` wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
- Outputs `ins_word`/`ins_pc`/`ins_op`/`func_code` hold head entry; values undefined-but-stable (last head) when `ins_valid` low.

## Timing
- Reset values: `imem_req` 0 while `rst_n` low, `imem_addr` = `RESET_PC`, `ins_valid` 0, `ins_word` 0, `ins_pc` 0, state FETCH, `count` 0.
- First cycle after reset release: `imem_req` 1, `imem_addr` = `RESET_PC`.
- Ack-to-valid latency: 1 cycle (data pushed at ack edge, `ins_valid` high next cycle).
- Redirect-to-request: `imem_req` for new PC in cycle after redirect (FETCH case) or cycle after discard ack.
- `ins_valid` low the cycle after a redirect.
- Reset mid-transaction: state cleared asynchronously; the abandoned request is not completed and a late ack is ignored.
- Sustained throughput with zero-wait memory and `ins_ready` high: 1 instr/cycle at DEPTH 2, 1 instr/2 cycles at DEPTH 1.

## Configuration
- `FETCH_PREFETCH_EN` defined: DEPTH = 2 (two-entry FIFO, circular head/tail pointers).
- Not defined: DEPTH = 1 (single register); `imem_req` low whenever entry valid.

## Structure
- `include/define.v`: instruction field bit positions (OP [31:26], FUNC [5:0]), `RESET_PC` default, FSM state encodings.
- One sub-module `fetch_buffer`: DEPTH-parameterised {word, pc} FIFO with push/pop/flush and `count`.

## Test plan
- Reset release, zero-wait ack, `ins_ready` 1 -> addresses 0x0,0x4,0x8 issued on consecutive cycles; `ins_pc` 0x0 valid 1 cycle after first ack, `ins_op`/`func_code` match word fields.
- `ins_ready` 0 with prefetch -> after two acks `imem_req` drops, `count` 2; raising `ins_ready` for one cycle -> `imem_req` reasserts next cycle at 0x8.
- Memory stalls ack 3 cycles -> `imem_req`/`imem_addr` constant all 3 cycles; single push on ack.
- Redirect to 0x103 while request to 0x10 pending -> DISCARD, 0x10 data dropped, next request 0x100, no stale `ins_valid`.
- Redirect coincident with ack and pop -> ack data dropped, `ins_valid` 0 next cycle, next `imem_addr` = redirect target.
- `RESET_PC` 0xFFFF_FFFC -> second request address 0x0000_0000; assert `rst_n` low mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and helpers for the kanade32 fetch stage.
// Build with FETCH_PREFETCH_EN defined to get the two-entry prefetch buffer.
package fetch_unit_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry {word, pc} FIFO with push, pop and flush; the head entry is
// always presented on word_o/pc_o.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [31:0]      word_i,
    input  logic [31:0]      pc_i,
    output logic [31:0]      word_o,
    output logic [31:0]      pc_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage is rounded up to a power of two so pointers index it exactly.
    localparam int SLOTS = 2 ** PTR_W;

    logic [31:0]      word_q [SLOTS];
    logic [31:0]      pc_q   [SLOTS];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = ptr_inc(tail_q);
            if (pop_i)  head_d = ptr_inc(head_q);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i && !flush_i) begin
                word_q[tail_q] <= word_i;
                pc_q[tail_q]   <= pc_i;
            end
        end
    end

    assign word_o  = word_q[head_q];
    assign pc_o    = pc_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// kanade32 instruction fetch: single-outstanding imem request, small {word, pc}
// buffer, redirect flush. FETCH_PREFETCH_EN selects a two-entry buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic [31:0] ins_pc,
    output logic [5:0]  ins_op,
    output logic [5:0]  func_code
);
    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] count;
    logic             hs;
    logic             buf_push;
    logic             buf_pop;
    logic             buf_flush;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        buf_push   = 1'b0;
        buf_flush  = 1'b0;
        imem_addr  = fetch_pc_q;
        // rst_n gates the request so it is low for the whole reset assertion.
        if (state_q == ST_DISCARD) begin
            imem_req = rst_n;
        end else begin
            imem_req = rst_n && (count < CNT_W'(FETCH_DEPTH));
        end
        hs = imem_req && imem_ack;

        if (redirect) begin
            buf_flush = 1'b1;
            if (!imem_req || hs) begin
                fetch_pc_d = word_align(redirect_pc);
                state_d    = ST_FETCH;
            end else begin
                // Keep the old address on the bus until memory acks it.
                target_d = word_align(redirect_pc);
                state_d  = ST_DISCARD;
            end
        end else if (state_q == ST_DISCARD) begin
            if (hs) begin
                fetch_pc_d = target_q;
                state_d    = ST_FETCH;
            end
        end else if (hs) begin
            buf_push   = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    assign buf_pop = ins_valid && ins_ready && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
        end
    end

    fetch_buffer #(
        .DEPTH (FETCH_DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .flush_i (buf_flush),
        .word_i  (imem_rdata),
        .pc_i    (fetch_pc_q),
        .word_o  (ins_word),
        .pc_o    (ins_pc),
        .count_o (count)
    );

    assign ins_valid = (count != '0);
    assign ins_op    = ins_word[OP_MSB:OP_LSB];
    assign func_code = ins_word[FUNC_MSB:FUNC_LSB];

endmodule
